// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN output-stationary MAC array: clear, skewed operand issue, drain, hold result.
// Optional build macro CTRL_PERF_EN adds a saturating busy-cycle counter output (perf_cycles).
module systolic_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned K_MAX = 16,
    parameter int unsigned KW    = $clog2(K_MAX),
    parameter int unsigned TW    = $clog2(K_MAX + 2*N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW:0]     k_len,
    input  logic            res_ack,
    output logic            busy,
    output logic            err,
    output logic            pe_rst,
    output logic [N-1:0]    row_vld,
    output logic [N*KW-1:0] row_idx,
    output logic [N-1:0]    col_vld,
    output logic [N*KW-1:0] col_idx,
    output logic            res_valid
`ifdef CTRL_PERF_EN
   ,output logic [31:0]     perf_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_e;

    localparam int unsigned LW      = TW + KW + 2;
    localparam logic [KW:0] K_MAX_L = (KW+1)'(K_MAX);

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [KW:0]       k_q, k_d;

    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              pe_rst_q, pe_rst_d;
    logic              res_valid_q, res_valid_d;
    logic [N-1:0]      vld_q, vld_d;
    logic [N*KW-1:0]   idx_q, idx_d;

    logic              legal;
    logic              accept;
    logic [LW-1:0]     last_step;
    logic [LW-1:0]     rel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            pe_rst_q    <= 1'b1;
            res_valid_q <= 1'b0;
            vld_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            pe_rst_q    <= pe_rst_d;
            res_valid_q <= res_valid_d;
            vld_q       <= vld_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        k_d       = k_q;
        err_d     = 1'b0;
        legal     = (k_len != '0) && (k_len <= K_MAX_L);
        accept    = 1'b0;
        last_step = LW'(k_q) + LW'(2*N) - LW'(3);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        accept  = 1'b1;
                        k_d     = k_len;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (LW'(t_q) == last_step) begin
                    state_d = S_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DONE: begin
                if (res_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        busy_d      = (state_d != S_IDLE);
        pe_rst_d    = (state_d == S_IDLE) || (state_d == S_CLEAR);
        res_valid_d = (state_d == S_DONE);
        vld_d       = '0;
        idx_d       = '0;
        rel         = '0;
        if (state_d == S_RUN) begin
            for (int unsigned i = 0; i < N; i++) begin
                rel = LW'(t_d) - LW'(i);
                if ((LW'(t_d) >= LW'(i)) && (rel < LW'(k_q))) begin
                    vld_d[i]          = 1'b1;
                    idx_d[i*KW +: KW] = KW'(rel);
                end
            end
        end
    end

    // Row and column lanes share the same skew, so one register set feeds both edges.
    assign busy      = busy_q;
    assign err       = err_q;
    assign pe_rst    = pe_rst_q;
    assign res_valid = res_valid_q;
    assign row_vld   = vld_q;
    assign row_idx   = idx_q;
    assign col_vld   = vld_q;
    assign col_idx   = idx_q;

`ifdef CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=4, K_MAX=16); cycle 0 is the cycle start is driven.
module tb_systolic_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned K_MAX = 16;
    localparam int unsigned KW    = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KW:0]     k_len;
    logic            res_ack;
    logic            busy;
    logic            err;
    logic            pe_rst;
    logic [N-1:0]    row_vld;
    logic [N*KW-1:0] row_idx;
    logic [N-1:0]    col_vld;
    logic [N*KW-1:0] col_idx;
    logic            res_valid;
`ifdef CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .res_ack    (res_ack),
        .busy       (busy),
        .err        (err),
        .pe_rst     (pe_rst),
        .row_vld    (row_vld),
        .row_idx    (row_idx),
        .col_vld    (col_vld),
        .col_idx    (col_idx),
        .res_valid  (res_valid)
`ifdef CTRL_PERF_EN
       ,.perf_cycles(perf_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k_len=3 lane pattern for t=0..8, lane 0 in the low bit/nibble.
    logic [3:0]  vld_tab [9] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [15:0] idx_tab [9] = '{16'h0000, 16'h0001, 16'h0012, 16'h0120, 16'h1200,
                                 16'h2000, 16'h0000, 16'h0000, 16'h0000};

    logic rv_seen;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        k_len   = '0;
        res_ack = 1'b0;
        tick();
        tick();
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_pe_rst", 32'(pe_rst), 32'd1);
        check("rst_rvalid", 32'(res_valid), 32'd0);
        check("rst_vld",    32'(row_vld), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Job k_len=3, acked on the first DONE cycle.
        start = 1'b1;
        k_len = 5'd3;
        tick();
        start = 1'b0;
        check("k3_c1_busy",   32'(busy), 32'd1);
        check("k3_c1_pe_rst", 32'(pe_rst), 32'd1);
        check("k3_c1_vld",    32'(row_vld), 32'd0);
        for (int c = 2; c <= 10; c++) begin
            tick();
            check($sformatf("k3_c%0d_row_vld", c), 32'(row_vld), 32'(vld_tab[c-2]));
            check($sformatf("k3_c%0d_col_vld", c), 32'(col_vld), 32'(vld_tab[c-2]));
            check($sformatf("k3_c%0d_row_idx", c), 32'(row_idx), 32'(idx_tab[c-2]));
            check($sformatf("k3_c%0d_col_idx", c), 32'(col_idx), 32'(idx_tab[c-2]));
            check($sformatf("k3_c%0d_pe_rst", c),  32'(pe_rst), 32'd0);
            check($sformatf("k3_c%0d_rvalid", c),  32'(res_valid), 32'd0);
        end
        tick();
        check("k3_c11_rvalid", 32'(res_valid), 32'd1);
        check("k3_c11_busy",   32'(busy), 32'd1);
        check("k3_c11_vld",    32'(row_vld), 32'd0);
        check("k3_c11_idx",    32'(row_idx), 32'd0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("k3_c12_rvalid", 32'(res_valid), 32'd0);
        check("k3_c12_busy",   32'(busy), 32'd0);
`ifdef CTRL_PERF_EN
        check("k3_perf", perf_cycles, 32'd11);
        tick();
        check("k3_perf_hold", perf_cycles, 32'd11);
`endif

        // Job k_len=16 with a stray res_ack, a start during RUN and a delayed ack.
        start = 1'b1;
        k_len = 5'd16;
        tick();
        start = 1'b0;
        for (int r = 2; r <= 29; r++) begin
            tick();
            if (r == 2) begin
                check("k16_c2_vld", 32'(row_vld), 32'h1);
                check("k16_c2_idx", 32'(row_idx), 32'h0);
            end
            if (r == 6) begin
                check("k16_c6_err",  32'(err), 32'd0);
                check("k16_c6_busy", 32'(busy), 32'd1);
            end
            if (r == 17) begin
                check("k16_c17_vld", 32'(col_vld), 32'hF);
                check("k16_c17_idx", 32'(col_idx), 32'hCDEF);
            end
            if (r == 20) begin
                check("k16_c20_vld", 32'(row_vld), 32'h8);
                check("k16_c20_idx", 32'(row_idx), 32'hF000);
            end
            if (r == 21) check("k16_c21_vld", 32'(row_vld), 32'h0);
            if (r == 23) begin
                check("k16_c23_busy",   32'(busy), 32'd1);
                check("k16_c23_pe_rst", 32'(pe_rst), 32'd0);
                check("k16_c23_rvalid", 32'(res_valid), 32'd0);
            end
            if (r >= 24 && r <= 28) check($sformatf("k16_c%0d_rvalid", r), 32'(res_valid), 32'd1);
            if (r == 29) begin
                check("k16_c29_rvalid", 32'(res_valid), 32'd0);
                check("k16_c29_busy",   32'(busy), 32'd0);
            end
            res_ack = (r == 3) || (r == 28);
            start   = (r == 5) || (r == 29);
            k_len   = (r == 29) ? 5'd2 : 5'd3;
        end

        // Job k_len=2 started right after the previous exit; start+ack together in DONE.
        tick();
        start = 1'b0;
        check("k2_c1_busy", 32'(busy), 32'd1);
        for (int r = 2; r <= 10; r++) begin
            tick();
            if (r == 9) check("k2_c9_rvalid", 32'(res_valid), 32'd0);
        end
        check("k2_c10_rvalid", 32'(res_valid), 32'd1);
        start   = 1'b1;
        res_ack = 1'b1;
        tick();
        start   = 1'b0;
        res_ack = 1'b0;
        check("k2_c11_busy",   32'(busy), 32'd0);
        check("k2_c11_rvalid", 32'(res_valid), 32'd0);
        tick();
        check("k2_c12_busy", 32'(busy), 32'd0);

        // Illegal lengths.
        start = 1'b1;
        k_len = 5'd0;
        tick();
        start = 1'b0;
        check("k0_err",  32'(err), 32'd1);
        check("k0_busy", 32'(busy), 32'd0);
        tick();
        check("k0_err_drop", 32'(err), 32'd0);
        start = 1'b1;
        k_len = 5'd17;
        tick();
        start = 1'b0;
        check("k17_err",  32'(err), 32'd1);
        check("k17_busy", 32'(busy), 32'd0);
        tick();
        check("k17_err_drop", 32'(err), 32'd0);

        // Reset during RUN step 3.
        start = 1'b1;
        k_len = 5'd3;
        tick();
        start = 1'b0;
        for (int r = 2; r <= 5; r++) tick();
        check("rr_c5_vld", 32'(row_vld), 32'hE);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_busy",    32'(busy), 32'd0);
        check("rr_pe_rst",  32'(pe_rst), 32'd1);
        check("rr_row_vld", 32'(row_vld), 32'd0);
        check("rr_col_vld", 32'(col_vld), 32'd0);
        rv_seen = 1'b0;
        for (int r = 0; r < 20; r++) begin
            tick();
            rv_seen = rv_seen | res_valid | busy;
        end
        check("rr_no_resume", 32'(rv_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
